// File: rtl/ring_cnt_chk.sv
// Receive-side monitor for the 4-bit one-hot ring counter bus: index encode, rotation check,
// HUNT/LOCKED tracking and error counting. Optional revolution counter under RING_CHK_WRAP_CNT_EN.
module ring_cnt_chk #(
    parameter int LOCK_N = 3,
    parameter int ERR_W  = 8,
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              q3,
    input  logic              q2,
    input  logic              q1,
    input  logic              q0,
    output logic [1:0]        idx,
    output logic              valid,
    output logic              locked,
    output logic              err,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [WRAP_W-1:0] wrap_cnt
);
    localparam int RUN_W = (LOCK_N > 1) ? $clog2(LOCK_N) : 1;

    typedef enum logic {HUNT, LOCKED} state_t;

    state_t           state, state_nxt;
    logic [RUN_W-1:0] run, run_nxt;
    logic [3:0]       s, prev, rot;
    logic             prev_ok, oh, step_ok, err_nxt;
    logic [1:0]       enc;

    assign s       = {q3, q2, q1, q0};
    assign oh      = $onehot(s);
    assign rot     = {prev[2:0], prev[3]};
    assign step_ok = oh & prev_ok & (s == rot);
    assign locked  = (state == LOCKED);

    always_comb begin
        enc = 2'd0;
        case (s)
            4'b0010: enc = 2'd1;
            4'b0100: enc = 2'd2;
            4'b1000: enc = 2'd3;
            default: enc = 2'd0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        run_nxt   = run;
        err_nxt   = 1'b0;
        if (en) begin
            case (state)
                HUNT: begin
                    if (!step_ok) begin
                        run_nxt = '0;
                    end else if (run == RUN_W'(LOCK_N - 1)) begin
                        state_nxt = LOCKED;
                        run_nxt   = '0;
                    end else begin
                        run_nxt = run + RUN_W'(1);
                    end
                end
                LOCKED: begin
                    if (!step_ok) begin
                        err_nxt   = 1'b1;
                        state_nxt = HUNT;
                        run_nxt   = '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= HUNT;
            run     <= '0;
            prev    <= 4'b0000;
            prev_ok <= 1'b0;
            valid   <= 1'b0;
            idx     <= 2'd0;
            err     <= 1'b0;
            err_cnt <= '0;
        end else if (en) begin
            state   <= state_nxt;
            run     <= run_nxt;
            prev    <= s;
            prev_ok <= oh;
            valid   <= oh;
            err     <= err_nxt;
            if (oh)
                idx <= enc;
            // saturate rather than wrap so a flood of breaks stays visible
            if (err_nxt && !(&err_cnt))
                err_cnt <= err_cnt + ERR_W'(1);
        end else begin
            err <= 1'b0;
        end
    end

`ifdef RING_CHK_WRAP_CNT_EN
    // a good q3->q0 step while already locked closes one revolution
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            wrap_cnt <= '0;
        else if (en && state == LOCKED && step_ok && s == 4'b0001)
            wrap_cnt <= wrap_cnt + WRAP_W'(1);
    end
`else
    assign wrap_cnt = '0;
`endif

endmodule

// File: tb/tb_ring_cnt_chk.sv
// Directed bench for ring_cnt_chk: lock/break/hold/enable/saturation/reset/revolution checks
// on a default instance and an ERR_W=2 instance sharing the same bus.
module tb_ring_cnt_chk;
    logic       clk, reset, en, q3, q2, q1, q0;
    logic [1:0] idx, idx2;
    logic       valid, valid2, locked, locked2, err, err2;
    logic [7:0] err_cnt, wrap_cnt, wrap_cnt2;
    logic [1:0] err_cnt2;
    int         ntot, npass, nfail;

`ifdef RING_CHK_WRAP_CNT_EN
    localparam int WEN = 1;
`else
    localparam int WEN = 0;
`endif

    ring_cnt_chk #(.LOCK_N(3), .ERR_W(8), .WRAP_W(8)) dut (
        .clk(clk), .reset(reset), .en(en), .q3(q3), .q2(q2), .q1(q1), .q0(q0),
        .idx(idx), .valid(valid), .locked(locked), .err(err),
        .err_cnt(err_cnt), .wrap_cnt(wrap_cnt)
    );

    ring_cnt_chk #(.LOCK_N(3), .ERR_W(2), .WRAP_W(8)) dut2 (
        .clk(clk), .reset(reset), .en(en), .q3(q3), .q2(q2), .q1(q1), .q0(q0),
        .idx(idx2), .valid(valid2), .locked(locked2), .err(err2),
        .err_cnt(err_cnt2), .wrap_cnt(wrap_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic [3:0] v, input logic e = 1'b1);
        {q3, q2, q1, q0} = v;
        en = e;
        @(posedge clk);
        #1;
    endtask

    task automatic co(input string tag, input logic [1:0] ei, input logic ev,
                      input logic el, input logic ee, input int ec);
        chk({tag, ".idx"},     {30'd0, idx},       {30'd0, ei});
        chk({tag, ".valid"},   {31'd0, valid},     {31'd0, ev});
        chk({tag, ".locked"},  {31'd0, locked},    {31'd0, el});
        chk({tag, ".err"},     {31'd0, err},       {31'd0, ee});
        chk({tag, ".err_cnt"}, {24'd0, err_cnt},   ec);
        chk({tag, ".cnt2"},    {30'd0, err_cnt2},  (ec > 3) ? 3 : ec);
        chk({tag, ".locked2"}, {31'd0, locked2},   {31'd0, el});
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".d1"}, {idx, valid, locked, err, err_cnt, wrap_cnt}, 0);
        chk({tag, ".d2"}, {idx2, valid2, locked2, err2, err_cnt2, wrap_cnt2}, 0);
    endtask

    initial begin
        logic [3:0] rev [4];
        rev[0] = 4'b0001; rev[1] = 4'b0010; rev[2] = 4'b0100; rev[3] = 4'b1000;
        ntot = 0; npass = 0; nfail = 0;
        reset = 1'b0; en = 1'b0; {q3, q2, q1, q0} = 4'b0000;
        #3;
        chk_zero("reset");
        @(negedge clk);
        reset = 1'b1;

        // first lock: first sample has no reference, so lock after the 4th
        drv(4'b0001); co("t1a", 0, 1, 0, 0, 0);
        drv(4'b0010); co("t1b", 1, 1, 0, 0, 0);
        drv(4'b0100); co("t1c", 2, 1, 0, 0, 0);
        drv(4'b1000); co("t1d", 3, 1, 1, 0, 0);

        // non-one-hot break, then relock
        drv(4'b0011); co("t2a", 3, 0, 0, 1, 1);
        drv(4'b0001); co("t2b", 0, 1, 0, 0, 1);
        drv(4'b0010); co("t2c", 1, 1, 0, 0, 1);
        drv(4'b0100); co("t2d", 2, 1, 0, 0, 1);
        drv(4'b1000); co("t2e", 3, 1, 1, 0, 1);

        // hold and reverse, plus a skip mid-hunt that restarts the run
        drv(4'b0001); co("t3a", 0, 1, 1, 0, 1);
        chk("t3.wrap1", {24'd0, wrap_cnt}, WEN);
        drv(4'b0010); co("t3b", 1, 1, 1, 0, 1);
        drv(4'b0100); co("t3c", 2, 1, 1, 0, 1);
        drv(4'b0100); co("t3hold", 2, 1, 0, 1, 2);
        drv(4'b0010); co("t3rev", 1, 1, 0, 0, 2);
        drv(4'b0100); co("t3d", 2, 1, 0, 0, 2);
        drv(4'b1000); co("t3e", 3, 1, 0, 0, 2);
        drv(4'b0010); co("t3skip", 1, 1, 0, 0, 2);
        drv(4'b0100); co("t3f", 2, 1, 0, 0, 2);
        drv(4'b1000); co("t3g", 3, 1, 0, 0, 2);
        drv(4'b0001); co("t3lock", 0, 1, 1, 0, 2);

        // enable low: everything holds regardless of the bus
        drv(4'b0011, 1'b0); co("t4a", 0, 1, 1, 0, 2);
        drv(4'b1000, 1'b0); co("t4b", 0, 1, 1, 0, 2);
        drv(4'b0000, 1'b0); co("t4c", 0, 1, 1, 0, 2);
        drv(4'b0100, 1'b0); co("t4d", 0, 1, 1, 0, 2);
        drv(4'b1111, 1'b0); co("t4e", 0, 1, 1, 0, 2);
        drv(4'b0010);       co("t4resume", 1, 1, 1, 0, 2);
        drv(4'b0000);       co("t4brk", 1, 0, 0, 1, 3);
        drv(4'b0000, 1'b0); co("t4errclr", 1, 0, 0, 0, 3);

        // more breaks: ERR_W=2 instance saturates at 3
        drv(4'b0001); co("t5a", 0, 1, 0, 0, 3);
        drv(4'b0010); co("t5b", 1, 1, 0, 0, 3);
        drv(4'b0100); co("t5c", 2, 1, 0, 0, 3);
        drv(4'b1000); co("t5d", 3, 1, 1, 0, 3);
        drv(4'b1000); co("t5brk4", 3, 1, 0, 1, 4);
        drv(4'b0001); co("t5e", 0, 1, 0, 0, 4);
        drv(4'b0010); co("t5f", 1, 1, 0, 0, 4);
        drv(4'b0100); co("t5g", 2, 1, 1, 0, 4);
        drv(4'b0001); co("t5brk5", 0, 1, 0, 1, 5);
        drv(4'b0010); co("t5h", 1, 1, 0, 0, 5);
        drv(4'b0100); co("t5i", 2, 1, 0, 0, 5);
        drv(4'b1000); co("t5j", 3, 1, 1, 0, 5);
        drv(4'b1100); co("t5brk6", 3, 0, 0, 1, 6);
        drv(4'b0001); co("t5k", 0, 1, 0, 0, 6);
        drv(4'b0010); co("t5l", 1, 1, 0, 0, 6);
        drv(4'b0100); co("t5m", 2, 1, 0, 0, 6);
        drv(4'b1000); co("t5n", 3, 1, 1, 0, 6);
        chk("t5.wrap", {24'd0, wrap_cnt}, WEN);

        // asynchronous reset while locked, checked before the next edge
        reset = 1'b0;
        #2;
        chk_zero("t5.areset");
        @(negedge clk);
        reset = 1'b1;

        // lock, then three full revolutions
        for (int i = 0; i < 4; i++) drv(rev[i]);
        co("t6lock", 3, 1, 1, 0, 0);
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < 4; i++) drv(rev[i]);
        co("t6end", 3, 1, 1, 0, 0);
        chk("t6.wrap", {24'd0, wrap_cnt}, 3 * WEN);
        chk("t6.wrap2", {24'd0, wrap_cnt2}, 3 * WEN);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
